// File: rtl/domain_reset_sequencer.sv
// Staggered reset/enable sequencer for N downstream flop banks.
// Releases the bank resets in index order and enables each bank one stage later; shuts the banks down in reverse order.
module domain_reset_sequencer #(
    parameter int N_DOMAINS    = 4,
    parameter int STAGE_CYCLES = 8,
    parameter int CNT_W        = $clog2(STAGE_CYCLES + 1),
    parameter int IDX_W        = $clog2(N_DOMAINS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 STOP,
    output logic [N_DOMAINS-1:0] DOM_RST,
    output logic [N_DOMAINS-1:0] DOM_EN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [IDX_W-1:0]     STAGE
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RELEASE,
        RUN,
        SHUTDOWN
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_DOMAINS - 1);

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [N_DOMAINS-1:0]   rst_nx, en_nx;
    logic                   busy_nx, done_nx;
    logic [IDX_W-1:0]       stage_nx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            DOM_RST <= '1;
            DOM_EN  <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            STAGE   <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            DOM_RST <= rst_nx;
            DOM_EN  <= en_nx;
            BUSY    <= busy_nx;
            DONE    <= done_nx;
            STAGE   <= stage_nx;
        end
    end

    // Every output is computed here as a next value, so all outputs leave the block registered.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rst_nx   = DOM_RST;
        en_nx    = DOM_EN;
        busy_nx  = BUSY;
        done_nx  = DONE;
        stage_nx = STAGE;

        case (state)
            IDLE: begin
                if (START && !STOP) begin
                    state_nx = HOLD;
                    busy_nx  = 1'b1;
                    cnt_nx   = RELOAD;
                end
            end

            HOLD: begin
                if (STOP) begin
                    state_nx = SHUTDOWN;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    stage_nx = LAST;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    rst_nx[0] = 1'b0;
                    stage_nx  = '0;
                    cnt_nx    = RELOAD;
                    state_nx  = RELEASE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            RELEASE: begin
                if (STOP) begin
                    state_nx = SHUTDOWN;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    stage_nx = LAST;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    en_nx[STAGE] = 1'b1;
                    if (STAGE != LAST) begin
                        rst_nx[STAGE + 1'b1] = 1'b0;
                        stage_nx             = STAGE + 1'b1;
                        cnt_nx               = RELOAD;
                    end else begin
                        state_nx = RUN;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end

            RUN: begin
                if (STOP) begin
                    state_nx = SHUTDOWN;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    stage_nx = LAST;
                    cnt_nx   = '0;
                end
            end

            // One bank per cycle; re-asserting reset on a bank still held in reset is harmless.
            SHUTDOWN: begin
                en_nx[STAGE]  = 1'b0;
                rst_nx[STAGE] = 1'b1;
                if (STAGE == '0) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    stage_nx = STAGE - 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_domain_reset_sequencer.sv
// Directed bench for domain_reset_sequencer: expected output snapshots are queued when each step is driven
// and popped for comparison one cycle later, with invariant checks on every falling edge.
module tb_domain_reset_sequencer;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       STOP;
    logic [3:0] DOM_RST;
    logic [3:0] DOM_EN;
    logic       BUSY;
    logic       DONE;
    logic [1:0] STAGE;

    typedef struct packed {
        logic [3:0] rst;
        logic [3:0] en;
        logic       busy;
        logic       done;
        logic [1:0] stage;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  inv_on = 1'b0;

    domain_reset_sequencer #(
        .N_DOMAINS   (4),
        .STAGE_CYCLES(8)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .STOP   (STOP),
        .DOM_RST(DOM_RST),
        .DOM_EN (DOM_EN),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .STAGE  (STAGE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic snap_t mk(input logic [3:0] r, input logic [3:0] e, input logic b,
                                 input logic d, input logic [1:0] s);
        snap_t x;
        x.rst   = r;
        x.en    = e;
        x.busy  = b;
        x.done  = d;
        x.stage = s;
        return x;
    endfunction

    // Power-up expectation k edges after the START edge, from the staggered timing formulas (S=8, N=4).
    function automatic snap_t pu_exp(input int k);
        snap_t x;
        int    st;
        for (int j = 0; j < 4; j++) begin
            x.rst[j] = (k < (j + 1) * 8);
            x.en[j]  = (k >= (j + 2) * 8);
        end
        x.done = (k >= 40);
        x.busy = (k < 40);
        st = k / 8 - 1;
        if (st < 0) st = 0;
        if (st > 3) st = 3;
        x.stage = 2'(st);
        return x;
    endfunction

    task automatic check_pop();
        snap_t o;
        snap_t e;
        string tg;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty: observed 0 queued entries, expected at least 1");
        end
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            tg = tag_q.pop_front();
            o  = {DOM_RST, DOM_EN, BUSY, DONE, STAGE};
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed rst=%b en=%b busy=%b done=%b stage=%0d, expected rst=%b en=%b busy=%b done=%b stage=%0d",
                       tg, o.rst, o.en, o.busy, o.done, o.stage, e.rst, e.en, e.busy, e.done, e.stage);
            end
        end
    endtask

    task automatic apply_step(input logic s_start, input logic s_stop, input logic s_rst,
                              input string tag, input snap_t e);
        START = s_start;
        STOP  = s_stop;
        RST   = s_rst;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge CLK);
        #1;
        check_pop();
        START = 1'b0;
        STOP  = 1'b0;
        RST   = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (inv_on) begin
            checks++;
            assert (((DOM_EN & DOM_RST) === 4'b0000) && !(BUSY === 1'b1 && DONE === 1'b1)) else begin
                errors++;
                $error("FAIL invariant: observed en=%b rst=%b busy=%b done=%b, expected en&rst=0000 and not busy&done",
                       DOM_EN, DOM_RST, BUSY, DONE);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish by 100000ns, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        snap_t rs;
        rs    = mk(4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0);
        RST   = 1'b1;
        START = 1'b0;
        STOP  = 1'b0;

        for (int i = 0; i < 3; i++) apply_step(1'b0, 1'b0, 1'b1, $sformatf("reset_%0d", i), rs);
        inv_on = 1'b1;
        for (int i = 0; i < 50; i++) apply_step(1'b0, 1'b0, 1'b0, $sformatf("idle_%0d", i), rs);

        apply_step(1'b1, 1'b1, 1'b0, "start_stop_idle", rs);
        apply_step(1'b0, 1'b0, 1'b0, "after_start_stop", rs);

        apply_step(1'b1, 1'b0, 1'b0, "pu_k0", pu_exp(0));
        for (int k = 1; k <= 44; k++) begin
            apply_step((k == 5 || k == 20 || k == 38 || k == 42), 1'b0, 1'b0,
                       $sformatf("pu_k%0d", k), pu_exp(k));
        end

        apply_step(1'b0, 1'b1, 1'b0, "run_stop_u0", mk(4'b0000, 4'b1111, 1'b1, 1'b0, 2'd3));
        apply_step(1'b0, 1'b0, 1'b0, "sd_u1", mk(4'b1000, 4'b0111, 1'b1, 1'b0, 2'd2));
        apply_step(1'b1, 1'b0, 1'b0, "sd_u2", mk(4'b1100, 4'b0011, 1'b1, 1'b0, 2'd1));
        apply_step(1'b0, 1'b1, 1'b0, "sd_u3", mk(4'b1110, 4'b0001, 1'b1, 1'b0, 2'd0));
        apply_step(1'b0, 1'b0, 1'b0, "sd_u4", rs);
        apply_step(1'b0, 1'b0, 1'b0, "sd_idle", rs);

        apply_step(1'b1, 1'b0, 1'b0, "mid_k0", pu_exp(0));
        for (int k = 1; k < 20; k++) apply_step(1'b0, 1'b0, 1'b0, $sformatf("mid_k%0d", k), pu_exp(k));
        apply_step(1'b0, 1'b1, 1'b0, "mid_stop_k20", mk(4'b1100, 4'b0001, 1'b1, 1'b0, 2'd3));
        apply_step(1'b0, 1'b0, 1'b0, "mid_sd_k21", mk(4'b1100, 4'b0001, 1'b1, 1'b0, 2'd2));
        apply_step(1'b0, 1'b0, 1'b0, "mid_sd_k22", mk(4'b1100, 4'b0001, 1'b1, 1'b0, 2'd1));
        apply_step(1'b0, 1'b0, 1'b0, "mid_sd_k23", mk(4'b1110, 4'b0001, 1'b1, 1'b0, 2'd0));
        apply_step(1'b0, 1'b0, 1'b0, "mid_sd_k24", rs);

        apply_step(1'b1, 1'b0, 1'b0, "re_k0", pu_exp(0));
        for (int k = 1; k < 30; k++) apply_step(1'b0, 1'b0, 1'b0, $sformatf("re_k%0d", k), pu_exp(k));
        apply_step(1'b1, 1'b0, 1'b1, "rst_mid_k30", rs);
        for (int i = 0; i < 10; i++) apply_step(1'b0, 1'b0, 1'b0, $sformatf("post_rst_%0d", i), rs);

        inv_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
